// File: rtl/riscv_pipeline_ctrl_pkg.sv
// rtl/riscv_pipeline_ctrl_pkg.sv - shared types and codes for the pipeline sequencer
// Contents: FSM encodings (PIPE_RUN, PIPE_MC_WAIT), forward-select codes
// (FWD_RF, FWD_MEM, FWD_WB), default register-address width.
package riscv_pipeline_ctrl_pkg;

    localparam int RA_W_DEF = 5;

    typedef enum logic [0:0] {
        PIPE_RUN     = 1'b0,
        PIPE_MC_WAIT = 1'b1
    } pipe_state_e;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF  = 2'b00;
    localparam fwd_sel_t FWD_MEM = 2'b01;
    localparam fwd_sel_t FWD_WB  = 2'b10;

endpackage

// File: rtl/riscv_pipeline_ctrl_if.sv
// rtl/riscv_pipeline_ctrl_if.sv - datapath <-> pipeline sequencer signal bundle
// slave  modport: sequencer side (reads i_* hazard/status inputs, drives o_* enables/valids/forwards)
// master modport: datapath side (drives i_*, reads o_*)
interface riscv_pipeline_ctrl_if
    import riscv_pipeline_ctrl_pkg::*;
#(
    parameter int RA_W = RA_W_DEF
);
    logic            i_if_valid;
    logic [RA_W-1:0] i_id_rs1;
    logic [RA_W-1:0] i_id_rs2;
    logic            i_id_use_rs1;
    logic            i_id_use_rs2;
    logic [RA_W-1:0] i_ex_rd;
    logic [RA_W-1:0] i_mem_rd;
    logic [RA_W-1:0] i_wb_rd;
    logic            i_ex_rd_we;
    logic            i_mem_rd_we;
    logic            i_wb_rd_we;
    logic            i_ex_is_load;
    logic            i_ex_redirect;
    logic            i_ex_mc_start;
    logic            i_ex_mc_done;
    logic            i_mem_stall;

    logic            o_pc_en;
    logic            o_ifid_en;
    logic            o_idex_en;
    logic            o_exmem_en;
    logic            o_memwb_en;
    logic            o_vld_id;
    logic            o_vld_ex;
    logic            o_vld_mem;
    logic            o_vld_wb;
    fwd_sel_t        o_fwd_rs1;
    fwd_sel_t        o_fwd_rs2;
    logic            o_busy;

    modport slave (
        input  i_if_valid, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
               i_ex_rd, i_mem_rd, i_wb_rd, i_ex_rd_we, i_mem_rd_we, i_wb_rd_we,
               i_ex_is_load, i_ex_redirect, i_ex_mc_start, i_ex_mc_done, i_mem_stall,
        output o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en,
               o_vld_id, o_vld_ex, o_vld_mem, o_vld_wb, o_fwd_rs1, o_fwd_rs2, o_busy
    );

    modport master (
        output i_if_valid, i_id_rs1, i_id_rs2, i_id_use_rs1, i_id_use_rs2,
               i_ex_rd, i_mem_rd, i_wb_rd, i_ex_rd_we, i_mem_rd_we, i_wb_rd_we,
               i_ex_is_load, i_ex_redirect, i_ex_mc_start, i_ex_mc_done, i_mem_stall,
        input  o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en,
               o_vld_id, o_vld_ex, o_vld_mem, o_vld_wb, o_fwd_rs1, o_fwd_rs2, o_busy
    );

endinterface

// File: rtl/riscv_pipeline_ctrl_hazard_detect.sv
// rtl/riscv_pipeline_ctrl_hazard_detect.sv - RAW comparators for the ID-stage sources
// Build option: RISCV_PIPE_FWD_EN (defined: only load-use stalls, MEM/WB forwarding;
//               undefined: stall on any EX/MEM match, forward selects tied to regfile).
// Inputs : stage valids, ID rs1/rs2 + use flags, EX/MEM/WB rd + write enables, EX load flag.
// Outputs: o_hazard (stall ID one cycle), o_fwd_rs1/o_fwd_rs2 forward selects.
module riscv_hazard_detect
    import riscv_pipeline_ctrl_pkg::*;
#(
    parameter int RA_W = RA_W_DEF
) (
    input  logic            i_vld_id,
    input  logic            i_vld_ex,
    input  logic            i_vld_mem,
    input  logic            i_vld_wb,
    input  logic [RA_W-1:0] i_id_rs1,
    input  logic [RA_W-1:0] i_id_rs2,
    input  logic            i_id_use_rs1,
    input  logic            i_id_use_rs2,
    input  logic [RA_W-1:0] i_ex_rd,
    input  logic [RA_W-1:0] i_mem_rd,
    input  logic [RA_W-1:0] i_wb_rd,
    input  logic            i_ex_rd_we,
    input  logic            i_mem_rd_we,
    input  logic            i_wb_rd_we,
    input  logic            i_ex_is_load,
    output logic            o_hazard,
    output fwd_sel_t        o_fwd_rs1,
    output fwd_sel_t        o_fwd_rs2
);

    // x0 is hard-wired zero, so a write to it never creates a dependency.
    function automatic logic rd_hit(input logic prod_vld, input logic we,
                                    input logic [RA_W-1:0] rd, input logic use_rs,
                                    input logic [RA_W-1:0] rs);
        return prod_vld && we && (rd != '0) && use_rs && (rs == rd);
    endfunction

    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;

    always_comb begin
        ex_hit1  = i_vld_id && rd_hit(i_vld_ex,  i_ex_rd_we,  i_ex_rd,  i_id_use_rs1, i_id_rs1);
        ex_hit2  = i_vld_id && rd_hit(i_vld_ex,  i_ex_rd_we,  i_ex_rd,  i_id_use_rs2, i_id_rs2);
        mem_hit1 = i_vld_id && rd_hit(i_vld_mem, i_mem_rd_we, i_mem_rd, i_id_use_rs1, i_id_rs1);
        mem_hit2 = i_vld_id && rd_hit(i_vld_mem, i_mem_rd_we, i_mem_rd, i_id_use_rs2, i_id_rs2);
    end

`ifdef RISCV_PIPE_FWD_EN
    logic wb_hit1, wb_hit2;

    always_comb begin
        wb_hit1 = i_vld_id && rd_hit(i_vld_wb, i_wb_rd_we, i_wb_rd, i_id_use_rs1, i_id_rs1);
        wb_hit2 = i_vld_id && rd_hit(i_vld_wb, i_wb_rd_we, i_wb_rd, i_id_use_rs2, i_id_rs2);
        // ALU results in EX reach the ID consumer through the MEM bypass next
        // cycle; only a load's data is too late and needs the one-cycle bubble.
        o_hazard  = i_ex_is_load && (ex_hit1 || ex_hit2);
        // MEM holds the younger write, so it wins over WB.
        o_fwd_rs1 = mem_hit1 ? FWD_MEM : (wb_hit1 ? FWD_WB : FWD_RF);
        o_fwd_rs2 = mem_hit2 ? FWD_MEM : (wb_hit2 ? FWD_WB : FWD_RF);
    end
`else
    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{i_vld_wb, i_wb_rd, i_wb_rd_we, i_ex_is_load};

    // Without bypassing, ID waits until the producer has reached WB; the
    // write-before-read regfile then delivers the value.
    always_comb begin
        o_hazard  = ex_hit1 || ex_hit2 || mem_hit1 || mem_hit2;
        o_fwd_rs1 = FWD_RF;
        o_fwd_rs2 = FWD_RF;
    end
`endif

endmodule

// File: rtl/riscv_pipeline_ctrl.sv
// rtl/riscv_pipeline_ctrl.sv - pipeline register enable/valid sequencer for the 5-stage core
// Ports: i_clk, i_rstn (async, active-low), bus (riscv_pipeline_ctrl_if.slave) carrying
//        hazard/status inputs and the enables, stage valids, forward selects and o_busy.
// Build option: RISCV_PIPE_FWD_EN selects forwarding-aware hazard detection.
module riscv_pipeline_ctrl
    import riscv_pipeline_ctrl_pkg::*;
#(
    parameter int RA_W = RA_W_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    riscv_pipeline_ctrl_if.slave bus
);

    pipe_state_e state_q, state_d;
    logic        vld_id_q, vld_id_d;
    logic        vld_ex_q, vld_ex_d;
    logic        vld_mem_q, vld_mem_d;
    logic        vld_wb_q, vld_wb_d;
    logic        done_q, done_d;

    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        hazard;
    logic        redirect_go, mc_go, mc_exit;
    fwd_sel_t    fwd_rs1, fwd_rs2;

    riscv_hazard_detect #(.RA_W(RA_W)) u_hazard (
        .i_vld_id    (vld_id_q),
        .i_vld_ex    (vld_ex_q),
        .i_vld_mem   (vld_mem_q),
        .i_vld_wb    (vld_wb_q),
        .i_id_rs1    (bus.i_id_rs1),
        .i_id_rs2    (bus.i_id_rs2),
        .i_id_use_rs1(bus.i_id_use_rs1),
        .i_id_use_rs2(bus.i_id_use_rs2),
        .i_ex_rd     (bus.i_ex_rd),
        .i_mem_rd    (bus.i_mem_rd),
        .i_wb_rd     (bus.i_wb_rd),
        .i_ex_rd_we  (bus.i_ex_rd_we),
        .i_mem_rd_we (bus.i_mem_rd_we),
        .i_wb_rd_we  (bus.i_wb_rd_we),
        .i_ex_is_load(bus.i_ex_is_load),
        .o_hazard    (hazard),
        .o_fwd_rs1   (fwd_rs1),
        .o_fwd_rs2   (fwd_rs2)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q   <= PIPE_RUN;
            vld_id_q  <= 1'b0;
            vld_ex_q  <= 1'b0;
            vld_mem_q <= 1'b0;
            vld_wb_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vld_id_q  <= vld_id_d;
            vld_ex_q  <= vld_ex_d;
            vld_mem_q <= vld_mem_d;
            vld_wb_q  <= vld_wb_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        vld_id_d  = vld_id_q;
        vld_ex_d  = vld_ex_q;
        vld_mem_d = vld_mem_q;
        vld_wb_d  = vld_wb_q;
        done_d    = done_q;
        pc_en     = 1'b1;
        ifid_en   = 1'b1;
        idex_en   = 1'b1;
        exmem_en  = 1'b1;
        memwb_en  = 1'b1;

        // Redirect and multi-cycle start are only acted on from RUN; a redirect
        // also suppresses a coincident start since its instruction is leaving EX.
        redirect_go = (state_q == PIPE_RUN) && bus.i_ex_redirect && vld_ex_q;
        mc_go       = (state_q == PIPE_RUN) && bus.i_ex_mc_start && vld_ex_q && !redirect_go;
        mc_exit     = (state_q == PIPE_MC_WAIT) && (bus.i_ex_mc_done || done_q);

        if (bus.i_mem_stall) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
            // Remember a completion that lands while memory is frozen.
            if ((state_q == PIPE_MC_WAIT) && bus.i_ex_mc_done) begin
                done_d = 1'b1;
            end
        end else if (redirect_go) begin
            vld_id_d  = 1'b0;
            vld_ex_d  = 1'b0;
            vld_mem_d = vld_ex_q;
            vld_wb_d  = vld_mem_q;
        end else if ((state_q == PIPE_MC_WAIT) || mc_go) begin
            // The multi-cycle op parks in EX (including its start cycle) while
            // MEM/WB drain; MEM sees bubbles until the result is ready.
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            vld_mem_d = 1'b0;
            vld_wb_d  = vld_mem_q;
            if (mc_go) begin
                state_d = PIPE_MC_WAIT;
            end else if (mc_exit) begin
                state_d   = PIPE_RUN;
                done_d    = 1'b0;
                vld_mem_d = 1'b1;
                // ID/EX is held on exit, so EX must not keep a second copy.
                vld_ex_d  = 1'b0;
            end
        end else if (hazard) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            vld_ex_d  = 1'b0;
            vld_mem_d = vld_ex_q;
            vld_wb_d  = vld_mem_q;
        end else begin
            vld_id_d  = bus.i_if_valid;
            vld_ex_d  = vld_id_q;
            vld_mem_d = vld_ex_q;
            vld_wb_d  = vld_mem_q;
        end
    end

    assign bus.o_pc_en    = pc_en;
    assign bus.o_ifid_en  = ifid_en;
    assign bus.o_idex_en  = idex_en;
    assign bus.o_exmem_en = exmem_en;
    assign bus.o_memwb_en = memwb_en;
    assign bus.o_vld_id   = vld_id_q;
    assign bus.o_vld_ex   = vld_ex_q;
    assign bus.o_vld_mem  = vld_mem_q;
    assign bus.o_vld_wb   = vld_wb_q;
    assign bus.o_fwd_rs1  = fwd_rs1;
    assign bus.o_fwd_rs2  = fwd_rs2;
    assign bus.o_busy     = (state_q == PIPE_MC_WAIT);

endmodule
